fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the MIPS datapath, the successor to the single-cycle PC register. Owns the program counter, issues one outstanding request at a time to a variable-latency instruction memory over a valid/ready handshake, and buffers returned words in a small queue that feeds decode. Branch and jump redirects are computed internally (sign-extend/shift for branches, region-concatenate for jumps) and flush in-flight fetches.

## Interface
- XLEN, 32: PC and address width (≥ 32).
- RESET_VECTOR, 32'h0000_0000: PC after reset; must be word-aligned.
- QDEPTH, 2: instruction queue entries; power of two, ≥ 2.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch byte address, word-aligned.
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  response word valid (exactly one per accepted request, ≥ 1 cycle later).
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_mode  in  1  0 = branch, 1 = jump.
- redirect_pc  in  XLEN  PC of the redirecting instruction.
- redirect_imm  in  26  jump index; branch uses [15:0].
- inst_valid  out  1  queue head valid.
- inst_data  out  32  queue head instruction.
- inst_pc  out  XLEN  queue head PC.
- inst_ready  in  1  decode consumes head.

## Operation
- States: RUN (no request outstanding), WAIT (one accepted, response pending), DRAIN (one outstanding, response is stale).
- Request condition: state RUN, queue count < QDEPTH, no redirect this cycle. imem_req_addr = fetch_pc (registered).
- Request accepted (valid & ready): fetch_pc += 4 (mod 2^XLEN, wraps silently), RUN→WAIT; the accepted address is latched as resp_pc.
- Response in WAIT: push {resp_pc, data}; WAIT→RUN. Response in DRAIN: discarded; DRAIN→RUN. Response in RUN: ignored.
- Pop: inst_valid & inst_ready removes head. Push and pop in the same cycle when full are legal (count unchanged).
- Redirect target: branch = redirect_pc + 4 + (sext(imm[15:0]) << 2); jump = {(redirect_pc+4)[XLEN-1:28], imm[25:0], 2'b00}.
- Redirect: fetch_pc ← target; queue cleared; WAIT→DRAIN; RUN stays RUN; DRAIN stays DRAIN. Redirect overrides push, pop and request in the same cycle; a response arriving that cycle is discarded.
- An unaccepted request (valid, !ready) may be withdrawn only by redirect or reset; otherwise valid and address hold stable.

## Timing
- Reset values: fetch_pc = RESET_VECTOR, state RUN, queue empty, imem_req_valid 0, inst_valid 0, inst_data 0, inst_pc 0.
- imem_req_valid is first asserted in the cycle after reset deasserts.
- Request accepted at cycle T, response at T+k → inst_valid at T+k+1. Next request earliest at T+k+1 (one outstanding).
- Redirect at cycle R → inst_valid 0 at R+1; new request at R+1 if state RUN, else one cycle after the stale response.
- Reset mid-WAIT: state returns to RUN; a response arriving after reset is ignored.

## Configuration
- FETCH_PERF_EN defined: adds outputs stall_cnt (32) counting cycles with inst_valid = 0, and flush_cnt (32) counting redirects; both reset to 0, saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- fetch_pkg: state enum (RUN/WAIT/DRAIN), REDIR_BRANCH/REDIR_JUMP constants, INST_BYTES = 4, function computing the redirect target.
- Sub-module fetch_queue: synchronous FIFO (QDEPTH entries of {pc, inst}), push/pop/flush, full/empty/count outputs.

## Test plan
- Reset release, ready always 1, latency 1: addresses 0x0, 0x4, 0x8 issued every 2 cycles; inst_pc follows same sequence, inst_valid one cycle after each response.
- inst_ready held 0, QDEPTH 2: exactly 2 instructions queued, imem_req_valid stays 0; raising inst_ready resumes fetch at 0x8.
- Branch at redirect_pc 0x100, imm 16'hFFFE: next request 0xFC; queue flushed; inst_valid 0 the next cycle.
- Jump at redirect_pc 0x1000_0040, imm 26'h000_0010: next request 0x1000_0040.
- Redirect while WAIT with latency 3: stale response discarded, no queue entry; new request issued cycle after stale response.
- imem_req_ready low for 4 cycles: imem_req_addr constant throughout; reset during WAIT leaves inst_valid 0 and next request at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and redirect-target arithmetic for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic REDIR_BRANCH = 1'b0;
    localparam logic REDIR_JUMP   = 1'b1;
    localparam int   INST_BYTES   = 4;
    localparam int   TGT_W        = 64;

    // Evaluated at 64 bits; the caller keeps the low XLEN bits, which gives mod 2^XLEN wrap.
    function automatic logic [TGT_W-1:0] redirect_target(
        input logic             mode,
        input logic [TGT_W-1:0] pc,
        input logic [25:0]      imm
    );
        logic [TGT_W-1:0] seq_pc;
        logic [TGT_W-1:0] boff;
        seq_pc = pc + TGT_W'(INST_BYTES);
        boff   = {{(TGT_W-18){imm[15]}}, imm[15:0], 2'b00};
        if (mode == REDIR_JUMP) begin
            redirect_target = {seq_pc[TGT_W-1:28], imm, 2'b00};
        end else begin
            redirect_target = seq_pc + boff;
        end
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instruction} pairs; flush empties it in one cycle.
module fetch_queue #(
    parameter  int XLEN   = 32,
    parameter  int QDEPTH = 2,
    localparam int CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [XLEN-1:0]  push_pc,
    input  logic [31:0]      push_inst,
    output logic [XLEN-1:0]  head_pc,
    output logic [31:0]      head_inst,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [XLEN-1:0]  pc_q   [QDEPTH];
    logic [31:0]      inst_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_W'(QDEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_pc   = empty ? '0 : pc_q[rd_ptr_q];
    assign head_inst = empty ? '0 : inst_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                pc_q[wr_ptr_q]   <= push_pc;
                inst_q[wr_ptr_q] <= push_inst;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem handshake, redirect/flush, decode queue.
// Define FETCH_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              QDEPTH       = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic            redirect_mode,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [25:0]     redirect_imm,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [TGT_W-1:0] pc_ext, tgt;
    logic             unused_tgt;
    logic             req_fire, q_push, q_pop, q_full, q_empty;
    logic [CNT_W-1:0] q_count;

    always_comb begin
        pc_ext             = '0;
        pc_ext[XLEN-1:0]   = redirect_pc;
        tgt                = redirect_target(redirect_mode, pc_ext, redirect_imm);
    end
    assign unused_tgt = ^tgt;

    // Valid/ready: a request is offered while RUN with queue room and no redirect; once offered
    // it holds valid and address until accepted, withdrawn only by redirect or reset.
    assign imem_req_valid = !reset && (state_q == RUN) && (q_count < CNT_W'(QDEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign q_push         = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
    assign inst_valid     = !q_empty;
    assign q_pop          = inst_valid && inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        case (state_q)
            RUN: begin
                if (req_fire) begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
                    resp_pc_d  = fetch_pc_q;
                end
            end
            // A response in the redirect cycle retires the outstanding request, so no DRAIN needed.
            WAIT: begin
                if (imem_resp_valid)     state_d = RUN;
                else if (redirect_valid) state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_resp_valid) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (redirect_valid) fetch_pc_d = tgt[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_VECTOR;
            resp_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
        end
    end

    fetch_queue #(
        .XLEN   (XLEN),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .push_pc   (resp_pc_q),
        .push_inst (imem_resp_data),
        .head_pc   (inst_pc),
        .head_inst (inst_data),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Requests are gated on queue room, so a push into a full queue must coincide with a pop.
    assert property (@(posedge clk) disable iff (reset) q_push |-> (!q_full || q_pop));

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!inst_valid && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, back-pressure, branch/jump redirects,
// stale-response drain, request hold under !ready, and reset during an outstanding fetch.
module tb_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic        redirect_mode = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [25:0] redirect_imm = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b1;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int          n_vec = 0;
    int          n_miss = 0;
    int          lat = 1;
    int          pend = 0;
    logic [31:0] paddr = '0;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_mode   (redirect_mode),
        .redirect_pc     (redirect_pc),
        .redirect_imm    (redirect_imm),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, then play the memory's response timing.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (acc) begin
            pend  = lat;
            paddr = a;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = paddr ^ MAGIC;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_data", inst_data, 0);
        reset = 1'b0;
        #1;
        check("rel_req_valid", imem_req_valid, 1);
        check("rel_req_addr", imem_req_addr, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Sequential fetch, latency 1, decode always ready.
        lat = 1;
        reset_dut();
        tick();
        check("seq_c1_req_valid", imem_req_valid, 0);
        check("seq_c1_inst_valid", inst_valid, 0);
        tick();
        check("seq_c2_inst_valid", inst_valid, 1);
        check("seq_c2_inst_pc", inst_pc, 32'h0);
        check("seq_c2_inst_data", inst_data, 32'hDEAD_0000);
        check("seq_c2_req_valid", imem_req_valid, 1);
        check("seq_c2_req_addr", imem_req_addr, 32'h4);
        tick();
        check("seq_c3_inst_valid", inst_valid, 0);
        tick();
        check("seq_c4_inst_pc", inst_pc, 32'h4);
        check("seq_c4_req_addr", imem_req_addr, 32'h8);
        tick();
        tick();
        check("seq_c6_inst_pc", inst_pc, 32'h8);
        check("seq_c6_inst_data", inst_data, 32'hDEAD_0008);

        // Back-pressure fills the two-entry queue and stops requests.
        reset_dut();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp_full_inst_valid", inst_valid, 1);
        check("bp_full_inst_pc", inst_pc, 32'h0);
        check("bp_full_req_valid", imem_req_valid, 0);
        tick();
        tick();
        check("bp_hold_req_valid", imem_req_valid, 0);
        inst_ready = 1'b1;
        #1;
        check("bp_pop_req_valid", imem_req_valid, 0);
        tick();
        check("bp_resume_req_valid", imem_req_valid, 1);
        check("bp_resume_req_addr", imem_req_addr, 32'h8);
        check("bp_resume_inst_pc", inst_pc, 32'h4);
        check("bp_resume_inst_data", inst_data, 32'hDEAD_0004);

        // Branch with a negative offset flushes the queued entry.
        reset_dut();
        inst_ready = 1'b0;
        tick();
        tick();
        check("br_pre_inst_valid", inst_valid, 1);
        redirect_valid = 1'b1;
        redirect_mode  = 1'b0;
        redirect_pc    = 32'h0000_0100;
        redirect_imm   = 26'h000_FFFE;
        #1;
        check("br_req_blocked", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("br_inst_valid", inst_valid, 0);
        check("br_req_valid", imem_req_valid, 1);
        check("br_req_addr", imem_req_addr, 32'h0000_00FC);

        // Jump keeps the upper PC region of the delay slot.
        redirect_valid = 1'b1;
        redirect_mode  = 1'b1;
        redirect_pc    = 32'h1000_0040;
        redirect_imm   = 26'h000_0010;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("jmp_req_valid", imem_req_valid, 1);
        check("jmp_req_addr", imem_req_addr, 32'h1000_0040);
        inst_ready = 1'b1;
        tick();
        tick();
        check("jmp_inst_valid", inst_valid, 1);
        check("jmp_inst_pc", inst_pc, 32'h1000_0040);
        check("jmp_inst_data", inst_data, 32'hCEAD_0040);

        // Redirect while waiting, latency 3: stale response dropped, refetch after it.
        lat = 3;
        reset_dut();
        tick();
        redirect_valid = 1'b1;
        redirect_mode  = 1'b0;
        redirect_pc    = 32'h0000_0200;
        redirect_imm   = 26'h000_0004;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("drn_c2_req_valid", imem_req_valid, 0);
        tick();
        check("drn_c3_resp_seen", imem_resp_valid, 1);
        check("drn_c3_req_valid", imem_req_valid, 0);
        check("drn_c3_inst_valid", inst_valid, 0);
        tick();
        check("drn_c4_req_valid", imem_req_valid, 1);
        check("drn_c4_req_addr", imem_req_addr, 32'h0000_0214);
        check("drn_c4_inst_valid", inst_valid, 0);
        for (int i = 0; i < 4; i++) tick();
        check("drn_c8_inst_valid", inst_valid, 1);
        check("drn_c8_inst_pc", inst_pc, 32'h0000_0214);
        check("drn_c8_inst_data", inst_data, 32'hDEAD_0214);

        // Request held while memory stalls, then reset during the outstanding fetch.
        reset_dut();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_req_valid", imem_req_valid, 1);
            check("hold_req_addr", imem_req_addr, 32'h0);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        check("wrst_wait_req_valid", imem_req_valid, 0);
        imem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        check("wrst_inst_valid", inst_valid, 0);
        check("wrst_req_valid", imem_req_valid, 0);
        reset = 1'b0;
        #1;
        check("wrst_rel_req_valid", imem_req_valid, 1);
        check("wrst_rel_req_addr", imem_req_addr, 32'h0);
        tick();
        check("wrst_stale_seen", imem_resp_valid, 1);
        check("wrst_stale_req_addr", imem_req_addr, 32'h0);
        tick();
        check("wrst_stale_inst_valid", inst_valid, 0);
        imem_req_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
